// File: rtl/quad_gen.sv
// rtl/quad_gen.sv - quadrature encoder signal generator driven by step commands
//
// Turns a (steps, direction, period) command into A/B quadrature edges and
// keeps a wrapping position count that a downstream quadrature decoder
// should reproduce exactly.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   cmd_valid     command offered
//   cmd_ready     command can be accepted (IDLE and no abort)
//   cmd_steps     number of quadrature steps to issue
//   cmd_dir       1 = forward (A leads B), 0 = reverse
//   cmd_period    clk cycles per step, 0 behaves as 1
//   abort         stop the running command
//   quadA, quadB  registered quadrature outputs
//   busy          high while a command is running
//   done          one-cycle pulse on completion or abort
//   position      registered wrapping step position
module quad_gen #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16,
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             quadA,
  output logic             quadB,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [0:0]       state;
  logic [CNT_W-1:0] remaining;
  logic [DIV_W-1:0] divider;
  logic [DIV_W-1:0] period_q;
  logic             dir_q;

  logic [DIV_W-1:0] eff_period;
  logic             accept;
  logic             toggle_a;

  assign cmd_ready  = (state == IDLE) && !abort;
  assign busy       = (state == RUN);
  assign accept     = cmd_valid && cmd_ready;
  assign eff_period = (cmd_period == '0) ? DIV_ONE : cmd_period;

  // Sequence 00 -> 10 -> 11 -> 01 forward: when A equals B the forward step
  // toggles A, otherwise B. Reverse is the mirror image.
  assign toggle_a = ((quadA == quadB) == dir_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      divider   <= '0;
      period_q  <= DIV_ONE;
      dir_q     <= 1'b1;
      quadA     <= 1'b0;
      quadB     <= 1'b0;
      position  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              divider   <= eff_period - DIV_ONE;
              remaining <= cmd_steps;
              period_q  <= eff_period;
              dir_q     <= cmd_dir;
            end
          end
        end
        RUN: begin
          if (abort) begin
            // Abort beats a step scheduled on the same edge.
            state     <= IDLE;
            remaining <= '0;
            divider   <= '0;
            done      <= 1'b1;
          end else if (divider == '0) begin
            if (remaining != '0) begin
              if (toggle_a) quadA <= ~quadA;
              else          quadB <= ~quadB;
              position  <= dir_q ? (position + POS_ONE) : (position - POS_ONE);
              remaining <= remaining - CNT_ONE;
              divider   <= period_q - DIV_ONE;
              if (remaining == CNT_ONE) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              state <= IDLE;
            end
          end else begin
            divider <= divider - DIV_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_gen.sv
// tb/tb_quad_gen.sv - directed and loopback bench for quad_gen
module tb_quad_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        quadA, quadB, busy, done;
  logic [7:0]  position;

  int tests_run = 0;
  int tests_failed = 0;

  // Bench model of the outputs
  logic       m_a, m_b;
  logic [7:0] m_pos;
  logic [1:0] step_log[$];
  logic [1:0] fwd_seq[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  // Reference decoder: 3-stage synchroniser then transition decode
  logic [2:0] sa, sb;
  logic [7:0] dec_cnt;

  quad_gen #(.CNT_W(16), .DIV_W(16), .POS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period),
    .abort(abort), .quadA(quadA), .quadB(quadB), .busy(busy), .done(done),
    .position(position)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ph_idx(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      dec_cnt <= '0;
    end else begin
      sa <= {sa[1:0], quadA};
      sb <= {sb[1:0], quadB};
      if ({sa[2], sb[2]} != {sa[1], sb[1]}) begin
        if (ph_idx(sa[1], sb[1]) == ph_idx(sa[2], sb[2]) + 2'd1) dec_cnt <= dec_cnt + 8'd1;
        else dec_cnt <= dec_cnt - 8'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    abort = 1'b0;
    m_a = 1'b0;
    m_b = 1'b0;
    m_pos = '0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic model_step(input bit dir);
    logic [1:0] idx;
    idx = ph_idx(m_a, m_b);
    idx = dir ? idx + 2'd1 : idx - 2'd1;
    {m_a, m_b} = fwd_seq[idx];
    m_pos = dir ? m_pos + 8'd1 : m_pos - 8'd1;
    step_log.push_back({m_a, m_b});
  endtask

  // Issue one command and follow it cycle by cycle. Returns in the done cycle.
  task automatic run_cmd(input int steps, input bit dir, input int period, input int abort_step);
    int p, last, edges;
    logic [1:0] prev;
    p = (period == 0) ? 1 : period;
    step_log.delete();
    check("ready_pre", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_steps = 16'(steps);
    cmd_dir = dir;
    cmd_period = 16'(period);
    prev = {quadA, quadB};
    tick();
    // Garbage offered during RUN must be ignored
    cmd_steps = 16'd0;
    cmd_period = 16'd1;
    cmd_dir = ~dir;
    if (steps == 0) begin
      cmd_valid = 1'b0;
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_ab", {quadA, quadB}, prev);
      tick();
      check("zero_done_clr", done, 0);
      check("zero_ab2", {quadA, quadB}, prev);
      return;
    end
    last = (abort_step != 0) ? abort_step : steps;
    edges = last * p;
    for (int k = 1; k <= edges; k++) begin
      abort = (abort_step != 0) && (k == edges);
      prev = {quadA, quadB};
      tick();
      abort = 1'b0;
      if ((k % p == 0) && !((abort_step != 0) && (k == edges))) model_step(dir);
      check("ab", {quadA, quadB}, {m_a, m_b});
      check("pos", position, m_pos);
      check("busy", busy, (k < edges) ? 1 : 0);
      check("done", done, (k == edges) ? 1 : 0);
      check("one_toggle", ($countones(prev ^ {quadA, quadB}) <= 1) ? 1 : 0, 1);
    end
    cmd_valid = 1'b0;
    #1;
    check("ready_post", cmd_ready, 1);
  endtask

  initial begin
    logic [1:0] exp_f[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] exp_r[5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    logic [1:0] exp_b[3] = '{2'b11, 2'b10, 2'b00};

    // Reset state
    do_reset();
    check("rst_a", quadA, 0);
    check("rst_b", quadB, 0);
    check("rst_pos", position, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 1);
    abort = 1'b1;
    #1;
    check("ready_abort", cmd_ready, 0);

    // Abort in IDLE blocks acceptance and gives no done
    cmd_valid = 1'b1;
    cmd_steps = 16'd5;
    cmd_period = 16'd1;
    tick();
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);
    abort = 1'b0;
    cmd_valid = 1'b0;
    tick();
    check("idle_abort_done2", done, 0);
    check("idle_abort_pos", position, 0);

    // Forward run: 4 steps, period 3
    run_cmd(4, 1'b1, 3, 0);
    check("fwd_len", step_log.size(), 4);
    for (int i = 0; i < 4 && i < step_log.size(); i++) check("fwd_seq", step_log[i], exp_f[i]);
    check("fwd_pos", position, 4);
    tick();
    check("fwd_done_once", done, 0);

    // Reverse with wrap
    do_reset();
    run_cmd(5, 1'b0, 2, 0);
    check("rev_len", step_log.size(), 5);
    for (int i = 0; i < 5 && i < step_log.size(); i++) check("rev_seq", step_log[i], exp_r[i]);
    check("rev_pos", position, 8'hFB);
    tick();
    check("rev_done_once", done, 0);

    // Degenerate fields
    do_reset();
    run_cmd(0, 1'b1, 7, 0);
    check("zero_pos", position, 0);
    check("zero_busy2", busy, 0);
    run_cmd(3, 1'b1, 0, 0);
    check("p0_pos", position, 3);
    check("p0_ab", {quadA, quadB}, 2'b01);
    tick();

    // Abort on the 10th scheduled step
    do_reset();
    run_cmd(100, 1'b1, 4, 10);
    check("abort_len", step_log.size(), 9);
    check("abort_pos", position, 9);
    check("abort_ab", {quadA, quadB}, 2'b10);
    repeat (3) begin
      tick();
      check("abort_hold_ab", {quadA, quadB}, 2'b10);
      check("abort_hold_pos", position, 9);
      check("abort_done_once", done, 0);
      check("abort_ready", cmd_ready, 1);
    end

    // Back-to-back with reversal, second accepted in the done cycle
    do_reset();
    run_cmd(3, 1'b1, 2, 0);
    check("b2b_mid_ab", {quadA, quadB}, 2'b01);
    run_cmd(3, 1'b0, 2, 0);
    check("b2b_len", step_log.size(), 3);
    for (int i = 0; i < 3 && i < step_log.size(); i++) check("b2b_seq", step_log[i], exp_b[i]);
    check("b2b_pos", position, 0);
    tick();

    // Reset mid-run
    do_reset();
    cmd_valid = 1'b1;
    cmd_steps = 16'd10;
    cmd_dir = 1'b1;
    cmd_period = 16'd2;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    check("mid_pre_pos", position, 2);
    check("mid_pre_ab", {quadA, quadB}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ab", {quadA, quadB}, 2'b00);
    check("mid_rst_pos", position, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    m_a = 1'b0;
    m_b = 1'b0;
    m_pos = '0;
    tick();
    check("mid_post_done", done, 0);

    // Loopback against the reference decoder
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_cmd(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), int'($urandom_range(2, 50)), 0);
      repeat (5) tick();
      check("loop_dec", dec_cnt, m_pos);
      check("loop_pos", position, m_pos);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/quad_gen.md
Name: quad_gen

Overview:
- Quadrature encoder signal generator: converts step commands into A/B quadrature waveforms.
- Drives motor-encoder decoder inputs for loopback self-test and motor-less bring-up.
- Sits between the command logic and the decoder's quadA/quadB pins.
- Keeps its own position counter, which must track the decoder count exactly.

Parameters:
- CNT_W, 16, width of the step-count field of a command.
- DIV_W, 16, width of the step-period field, in clk cycles per quadrature step.
- POS_W, 8, width of the position counter; matches the decoder count width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted; equals (state==IDLE) && !abort.
- cmd_steps  in  CNT_W  number of quadrature steps (edges), unsigned.
- cmd_dir  in  1  1 = forward (A leads B, decoder counts up); 0 = reverse.
- cmd_period  in  DIV_W  clk cycles between steps; 0 is treated as 1.
- abort  in  1  stop the current command.
- quadA  out  1  channel A, registered.
- quadB  out  1  channel B, registered.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a command completes or is aborted.
- position  out  POS_W  signed-wrapping step position, registered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; quadA=0, quadB=0 (phase 00); position=0; busy=0; done=0; divider=0; remaining=0.
  - cmd_ready reads 1 unless abort is high.
- States: IDLE, RUN.
- Accept: at a rising edge with cmd_valid && cmd_ready, latch steps, dir and effective period P (P = max(cmd_period,1)).
  - If steps==0: stay in IDLE; done=1 in the following cycle; no output edges.
  - Else: go to RUN; busy=1 from the next cycle; divider loaded with P-1; remaining=steps.
- RUN:
  - The divider decrements each cycle.
  - When the divider is 0 and remaining>0:
    - Advance the phase one step.
    - position += 1 (forward) or -= 1 (reverse), modulo 2^POS_W.
    - remaining -= 1.
    - Reload the divider with P-1.
  - quadA, quadB and position all update on the same edge.
  - First edge occurs P cycles after the accept edge. Step k occurs at accept edge + k*P.
- Phase sequence (A,B):
  - Forward: 00 -> 10 -> 11 -> 01 -> 00.
  - Reverse: the same sequence traversed backwards.
  - Exactly one of A or B toggles per step; never both.
- Completion:
  - On the edge that issues the last step: state goes to IDLE; busy=0 and done=1 in the following cycle.
  - A new command may be accepted in the cycle done is high.
  - That command's first edge is separated from the previous command's last edge by at least P cycles.
- Phase persistence: the phase is never reset between commands. A new command continues from the current A/B levels in either direction.
- Direction reversal between commands is legal; the first step of the reversed command undoes the last step of the previous one.
- Abort:
  - In RUN: go to IDLE at the next edge; no further steps are issued; A/B and position hold; done pulses once; remaining is cleared.
  - Abort on the same edge as a scheduled step: abort wins and the step is not issued.
  - In IDLE: cmd_ready=0 and no command is accepted; no done pulse.
- cmd_valid in RUN: ignored (cmd_ready=0). The command fields are not sampled.
- Reset mid-run: outputs return to their reset values immediately; no done pulse.
- Reference loopback rule: the decoder (3-stage synchroniser, same clk) fed by quadA/quadB ends at a count equal to position, provided P >= 2.

Test Plan:
- Forward run: reset, accept steps=4, dir=1, period=3 at edge T0 -> (A,B) = 10@T0+3, 11@T0+6, 01@T0+9, 00@T0+12; position=4; done pulses in the cycle after T0+12; busy high for 12 cycles.
- Reverse wrap: from reset, accept steps=5, dir=0, period=2 -> (A,B) = 01, 11, 10, 00, 01 at 2-cycle spacing; final position=251 (0xFB); done pulses once.
- Degenerate fields:
  - steps=0, period=7 -> no A/B toggle; done high in the cycle after accept; busy stays 0.
  - steps=3, period=0 -> a step every cycle; position=3.
- Abort: steps=100, period=4; assert abort on the cycle of the 10th scheduled step -> exactly 9 steps issued; position=9; one done pulse; cmd_ready returns to 1; A/B hold.
- Back-to-back and reversal:
  - steps=3 fwd, then a new command accepted in the done cycle: steps=3 rev -> A/B retraces to 00; position=0; no double-toggle cycle.
  - Mid-run reset -> outputs 0 immediately.
- Loopback: quadA/quadB into the decoder; random commands with period 2..50 -> decoder count == position after every done.
